ram_fifo_ctrl: RTL and testbench

//  FIFO controller that drives the single-port ram (addr/wdata/wr in, rdata out) directly upstream of it.

---
 rtl/ram_fifo_ctrl_pkg.sv | 17 +
 rtl/ram_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared defaults and types for the ram-backed FIFO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ram_fifo_ctrl_pkg;

    // Default geometry, shared with the ram instantiated beside the controller.
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

    // What the single ram port is doing in the current cycle.
    typedef enum logic [1:0] {
        RAM_IDLE  = 2'd0,
        RAM_READ  = 2'd1,
        RAM_WRITE = 2'd2
    } ram_op_e;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external single-port ram (async read, sync write) plus one output register.
// Latency: push into an empty FIFO shows at pop 1 cycle later (bypass); otherwise via a ram read into the head.
// Backpressure: push_ready depends only on state and pop_ready; pushes stall on head-refill read cycles and when full.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   flush                 synchronous clear of pointers/count/head (ram contents untouched)
//   push_valid/data/ready producer handshake
//   pop_valid/data/ready  consumer handshake, pop_data is registered
//   level                 entries held = ram count + head register
//   ram_addr/wdata/wr     to the ram; ram_rdata is its combinational read of mem[ram_addr]
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH   // must equal 2**ADDR_WIDTH so pointers wrap naturally
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ready,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    input  logic                  pop_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_wr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;

    logic    out_free;
    logic    rd_req;
    logic    bypass;
    logic    push_fire;
    logic    wr_en;
    ram_op_e ram_op;

    // The head register can take a new value when it is empty or being drained now.
    assign out_free = !pop_valid || pop_ready;
    assign rd_req   = (ram_cnt != '0) && out_free;
    // With nothing in the ram, a push can skip the ram and land in the head directly.
    assign bypass   = (ram_cnt == '0) && out_free;

    // rd_req and a ram write are mutually exclusive: the read owns the port, so pushes
    // that would need the ram wait one cycle. bypass and rd_req are also exclusive.
    assign push_ready = bypass || (!rd_req && (ram_cnt != FULL_CNT));
    assign push_fire  = push_valid && push_ready;
    assign wr_en      = push_fire && !bypass;

    assign level = ram_cnt + {{ADDR_WIDTH{1'b0}}, pop_valid};

    always_comb begin
        ram_op = RAM_IDLE;
        if (rd_req) begin
            ram_op = RAM_READ;
        end else if (wr_en) begin
            ram_op = RAM_WRITE;
        end
    end

    // Idle cycles park the address on wr_ptr so the write path is already set up.
    assign ram_addr  = (ram_op == RAM_READ) ? rd_ptr : wr_ptr;
    assign ram_wdata = push_data;
    assign ram_wr    = (ram_op == RAM_WRITE) && !reset;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            // Head register: refill from ram first, else bypass a push, else drain.
            if (rd_req) begin
                pop_data  <= ram_rdata;
                pop_valid <= 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (bypass && push_fire) begin
                pop_data  <= push_data;
                pop_valid <= 1'b1;
            end else if (pop_valid && pop_ready) begin
                pop_valid <= 1'b0;
            end

            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (rd_req) begin
                ram_cnt <= ram_cnt - 1'b1;
            end else if (wr_en) begin
                ram_cnt <= ram_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural async-read ram alongside it.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       push_valid = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       push_ready;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic       pop_ready = 1'b0;
    logic [8:0] level;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_wr;
    logic [7:0] ram_rdata;

    always #5 clk = ~clk;

    ram_fifo_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (pop_ready),
        .level      (level),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wr     (ram_wr),
        .ram_rdata  (ram_rdata)
    );

    // Ram beside the controller: synchronous write, asynchronous read.
    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Scoreboard and independent occupancy model.
    logic [7:0]  sb_q [$];
    logic [15:0] wr_log [$];
    int          tb_level  = 0;
    int          pop_total = 0;
    int          stall_chk = 0;
    bit          run_mon   = 1'b0;
    bit          t5_on     = 1'b0;
    bit          t5_done   = 1'b0;

    // Inputs change only at posedge+1, so the negedge sees this cycle's handshake.
    always @(negedge clk) begin
        if (reset) begin
            check("wr_in_rst", {31'd0, ram_wr}, 32'd0);
        end else if (run_mon) begin
            check("level", {23'd0, level}, tb_level);
            if (ram_wr) wr_log.push_back({ram_addr, ram_wdata});
            if (t5_on && (int'(level) - int'(pop_valid) != 0) && (!pop_valid || pop_ready)) begin
                stall_chk++;
                check("rd_stall", {31'd0, push_ready}, 32'd0);
            end
            if (flush) begin
                sb_q.delete();
                tb_level = 0;
            end else begin
                if (pop_valid && pop_ready) begin
                    pop_total++;
                    tb_level--;
                    if (sb_q.size() == 0) check("pop_unexp", 32'd1, 32'd0);
                    else check("pop_dat", {24'd0, pop_data}, {24'd0, sb_q.pop_front()});
                end
                if (push_valid && push_ready) begin
                    sb_q.push_back(push_data);
                    tb_level++;
                end
            end
        end
    end

    task automatic do_push(input logic [7:0] d);
        bit got = 1'b0;
        push_valid = 1'b1;
        push_data  = d;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (push_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        push_valid = 1'b0;
        if (!got) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done = 1'b0;
        pop_ready = 1'b1;
        for (int t = 0; t < 1200; t++) begin
            @(negedge clk);
            if (level == 9'd0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        pop_ready = 1'b0;
    endtask

    initial begin
        int pops0;

        // 1: reset state
        cycles(2);
        reset   = 1'b0;
        run_mon = 1'b1;
        check("rst_pop_valid", {31'd0, pop_valid}, 32'd0);
        check("rst_level", {23'd0, level}, 32'd0);
        check("rst_push_ready", {31'd0, push_ready}, 32'd1);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);

        // 2: push into empty FIFO goes through the bypass
        wr_log.delete();
        do_push(8'h55);
        check("t2_pop_valid", {31'd0, pop_valid}, 32'd1);
        check("t2_pop_data", {24'd0, pop_data}, 32'h55);
        check("t2_level", {23'd0, level}, 32'd1);
        check("t2_no_ram_wr", wr_log.size(), 32'd0);
        pop_ready = 1'b1;
        cycles(1);
        pop_ready = 1'b0;

        // 3: back-to-back pushes spill into ram, then pop one per cycle
        wr_log.delete();
        do_push(8'h55);
        do_push(8'h56);
        do_push(8'h57);
        check("t3_level", {23'd0, level}, 32'd3);
        check("t3_wr_cnt", wr_log.size(), 32'd2);
        if (wr_log.size() == 2) begin
            check("t3_wr0", {16'd0, wr_log[0]}, {16'd0, 8'd0, 8'h56});
            check("t3_wr1", {16'd0, wr_log[1]}, {16'd0, 8'd1, 8'h57});
        end
        pops0 = pop_total;
        pop_ready = 1'b1;
        cycles(3);
        check("t3_pops", pop_total - pops0, 32'd3);
        check("t3_empty", {31'd0, pop_valid}, 32'd0);
        pop_ready = 1'b0;

        // 4: fill to DEPTH+1, reject extra push, drain with wrap
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        for (int i = 0; i < 257; i++) do_push(8'(i));
        check("t4_level", {23'd0, level}, 32'd257);
        check("t4_push_ready", {31'd0, push_ready}, 32'd0);
        check("t4_wr_wrap", {24'd0, ram_addr}, 32'd0);
        push_valid = 1'b1;
        push_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_full_ready", {31'd0, push_ready}, 32'd0);
        end
        @(posedge clk); #1;
        push_valid = 1'b0;
        check("t4_level_hold", {23'd0, level}, 32'd257);
        drain();
        check("t4_ptr_wrap", {24'd0, ram_addr}, 32'd0);

        // 5: random stream with random consumer stalls
        for (int i = 0; i < 6; i++) do_push(8'($urandom_range(0, 255)));
        t5_on = 1'b1;
        pops0 = pop_total;
        fork
            begin
                for (int i = 0; i < 1000; i++) do_push(8'($urandom_range(0, 255)));
                t5_done = 1'b1;
            end
            begin
                while (!t5_done) begin
                    @(posedge clk); #1;
                    pop_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        t5_on = 1'b0;
        check("t5_pops", pop_total - pops0, 32'd1006);
        check("t5_stall_seen", {31'd0, stall_chk > 0}, 32'd1);

        // 6: flush mid-stream
        for (int i = 0; i < 5; i++) do_push(8'(8'h20 + i));
        check("t6_level5", {23'd0, level}, 32'd5);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        check("t6_level0", {23'd0, level}, 32'd0);
        check("t6_pop_valid", {31'd0, pop_valid}, 32'd0);
        do_push(8'h11);
        check("t6_head_valid", {31'd0, pop_valid}, 32'd1);
        check("t6_head_data", {24'd0, pop_data}, 32'h11);
        drain();
        check("sb_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
